// File: rtl/game_timer_ctrl.sv
// Countdown game clock: divides the tick pulse down to seconds and counts a BCD M:SS
// value down from a loaded minute count, flagging expiry with a one-cycle timeUp pulse.
module game_timer_ctrl #(
    parameter int TICKS_PER_SEC = 1000,
    parameter int MAX_MIN       = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tickIn,
    input  logic       start,
    input  logic       pauseToggle,
    input  logic [3:0] loadMin,
    output logic [3:0] minDigit,
    output logic [3:0] secTens,
    output logic [3:0] secOnes,
    output logic       running,
    output logic       expired,
    output logic       timeUp
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;
    localparam logic [1:0] ST_EXPIRED = 2'd3;

    localparam logic [9:0] PRESC_MAX = 10'(TICKS_PER_SEC - 1);
    localparam logic [3:0] MIN_LIMIT = 4'(MAX_MIN);

    logic [1:0] state_reg, state_next;
    logic [9:0] presc_reg, presc_next;
    logic [3:0] min_reg, min_next;
    logic [3:0] tens_reg, tens_next;
    logic [3:0] ones_reg, ones_next;
    logic       running_reg, running_next;
    logic       expired_reg, expired_next;
    logic       time_up_reg, time_up_next;

    logic [3:0] load_clamped;
    logic       time_zero;
    logic       last_second;

    assign load_clamped = (loadMin > MIN_LIMIT) ? MIN_LIMIT : loadMin;
    assign time_zero    = (min_reg == 4'd0) && (tens_reg == 4'd0) && (ones_reg == 4'd0);
    assign last_second  = (min_reg == 4'd0) && (tens_reg == 4'd0) && (ones_reg == 4'd1);

    always_comb begin
        state_next   = state_reg;
        presc_next   = presc_reg;
        min_next     = min_reg;
        tens_next    = tens_reg;
        ones_next    = ones_reg;
        time_up_next = 1'b0;

        if (start) begin
            min_next   = load_clamped;
            tens_next  = 4'd0;
            ones_next  = 4'd0;
            presc_next = 10'd0;
            if (load_clamped == 4'd0) begin
                state_next   = ST_EXPIRED;
                time_up_next = 1'b1;
            end else begin
                state_next = ST_RUN;
            end
        end else begin
            case (state_reg)
                ST_RUN: begin
                    // A pause in the same cycle as a tick wins; the tick is simply lost.
                    if (pauseToggle) begin
                        state_next = ST_PAUSED;
                    end else if (tickIn) begin
                        if (presc_reg == PRESC_MAX) begin
                            presc_next = 10'd0;
                            if (!time_zero) begin
                                if (ones_reg != 4'd0) begin
                                    ones_next = ones_reg - 4'd1;
                                end else begin
                                    ones_next = 4'd9;
                                    if (tens_reg != 4'd0) begin
                                        tens_next = tens_reg - 4'd1;
                                    end else begin
                                        tens_next = 4'd5;
                                        min_next  = min_reg - 4'd1;
                                    end
                                end
                            end
                            if (last_second || time_zero) begin
                                state_next   = ST_EXPIRED;
                                time_up_next = 1'b1;
                            end
                        end else begin
                            presc_next = presc_reg + 10'd1;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (pauseToggle) begin
                        state_next = ST_RUN;
                    end
                end
                default: begin
                    state_next = state_reg;
                end
            endcase
        end
    end

    // Status flags are registered from the next state so they line up with the digits.
    assign running_next = (state_next == ST_RUN);
    assign expired_next = (state_next == ST_EXPIRED);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            presc_reg   <= 10'd0;
            min_reg     <= 4'd0;
            tens_reg    <= 4'd0;
            ones_reg    <= 4'd0;
            running_reg <= 1'b0;
            expired_reg <= 1'b0;
            time_up_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            presc_reg   <= presc_next;
            min_reg     <= min_next;
            tens_reg    <= tens_next;
            ones_reg    <= ones_next;
            running_reg <= running_next;
            expired_reg <= expired_next;
            time_up_reg <= time_up_next;
        end
    end

    assign minDigit = min_reg;
    assign secTens  = tens_reg;
    assign secOnes  = ones_reg;
    assign running  = running_reg;
    assign expired  = expired_reg;
    assign timeUp   = time_up_reg;

endmodule
